// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM port A bundle for ram_port_arbiter.
// slave = arbiter side, master = requesters + RAM side.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  err0, err1;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           ram_addr, ram_data, ram_we, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           ram_addr, ram_data, ram_we, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between two requesters, one access at a time.
// Optional RAM_ARB_BOUNDS_CHECK_EN rejects upper-bank addresses with gnt+err.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input logic              clk,
  input logic              reset,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t                      state;
  logic                        last_gnt;
  logic                        owner;
  logic [1:0]                  gnt, err, rvalid;
  logic [1:0][DATA_WIDTH-1:0]  rdata;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic [DATA_WIDTH-1:0]       ram_data;
  logic                        ram_we;
  logic                        busy;
  logic                        rd_pend;
  logic [DATA_WIDTH-1:0]       rd_hold;

  logic                        sel_ok, sel, sel_we, oob;
  logic [ADDR_WIDTH-1:0]       sel_addr;
  logic [DATA_WIDTH-1:0]       sel_wdata;

  // Tie goes to whoever was not granted last.
  always_comb begin
    sel_ok = 1'b0;
    sel    = 1'b0;
    if (bus.req0 && bus.req1) begin
      sel_ok = 1'b1;
      sel    = ~last_gnt;
    end else if (bus.req0 || bus.req1) begin
      sel_ok = 1'b1;
      sel    = bus.req1;
    end
  end

  assign sel_we    = sel ? bus.we1    : bus.we0;
  assign sel_addr  = sel ? bus.addr1  : bus.addr0;
  assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;

`ifdef RAM_ARB_BOUNDS_CHECK_EN
  assign oob = sel_addr[ADDR_WIDTH-1];
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      owner    <= 1'b0;
      gnt      <= '0;
      err      <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      rd_pend  <= 1'b0;
      rd_hold  <= '0;
    end else begin
      gnt     <= '0;
      err     <= '0;
      rvalid  <= '0;
      ram_we  <= 1'b0;
      rd_pend <= 1'b0;
      // Read data is staged one cycle past RDWAIT; owner is still the old value here.
      if (rd_pend) begin
        rvalid[owner] <= 1'b1;
        rdata[owner]  <= rd_hold;
      end
      case (state)
        IDLE: begin
          if (sel_ok) begin
            last_gnt   <= sel;
            gnt[sel]   <= 1'b1;
            if (oob) begin
              err[sel] <= 1'b1;
            end else begin
              owner    <= sel;
              ram_addr <= sel_addr;
              ram_data <= sel_wdata;
              ram_we   <= sel_we;
              busy     <= 1'b1;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (ram_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          rd_hold <= bus.ram_q;
          rd_pend <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0     = gnt[0];
  assign bus.gnt1     = gnt[1];
  assign bus.err0     = err[0];
  assign bus.err1     = err[1];
  assign bus.rvalid0  = rvalid[0];
  assign bus.rvalid1  = rvalid[1];
  assign bus.rdata0   = rdata[0];
  assign bus.rdata1   = rdata[1];
  assign bus.ram_addr = ram_addr;
  assign bus.ram_data = ram_data;
  assign bus.ram_we   = ram_we;
  assign bus.busy     = busy;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: transaction-level model scheduling expected outputs per cycle,
// a behavioural RAM on port A, and directed scenarios with literal expectations.
module tb_ram_port_arbiter;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural RAM port A: registered read, 1-cycle latency.
  logic [15:0] mem [1024];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_addr];
  end

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Model: expected outputs are scheduled per cycle at arbitration time.
  logic [1:0]  e_gnt [MAXC];
  logic [1:0]  e_err [MAXC];
  logic [1:0]  e_rv  [MAXC];
  logic        e_we  [MAXC];
  logic        e_busy[MAXC];
  logic [15:0] e_rdv0[MAXC];
  logic [15:0] e_rdv1[MAXC];
  logic [15:0] ref_mem [1024];
  logic [15:0] m_rdata0 = '0, m_rdata1 = '0, m_data = '0;
  logic [9:0]  m_addr = '0;
  logic        last = 1'b1;
  int          free_at = 0;

  initial begin
    for (int j = 0; j < 1024; j++) begin
      mem[j] = '0;
      ref_mem[j] = '0;
    end
    for (int j = 0; j < MAXC; j++) begin
      e_gnt[j] = '0; e_err[j] = '0; e_rv[j] = '0; e_we[j] = 1'b0; e_busy[j] = 1'b0;
      e_rdv0[j] = '0; e_rdv1[j] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc + 5 >= MAXC) begin
        $display("FAIL model_overflow cycle %0d", cyc);
        $fatal(1);
      end
      if (!reset) begin
        for (int j = cyc; j < cyc + 5; j++) begin
          e_gnt[j] = '0; e_err[j] = '0; e_rv[j] = '0; e_we[j] = 1'b0; e_busy[j] = 1'b0;
        end
        m_rdata0 = '0; m_rdata1 = '0; m_addr = '0; m_data = '0;
        last = 1'b1;
        free_at = cyc + 1;
      end else begin
        if (e_rv[cyc][0]) m_rdata0 = e_rdv0[cyc];
        if (e_rv[cyc][1]) m_rdata1 = e_rdv1[cyc];
        if (cyc >= free_at && (bus.req0 || bus.req1)) begin
          logic s, w, bad;
          logic [9:0] a;
          logic [15:0] d;
          s = (bus.req0 && bus.req1) ? !last : bus.req1;
          last = s;
          w = s ? bus.we1 : bus.we0;
          a = s ? bus.addr1 : bus.addr0;
          d = s ? bus.wdata1 : bus.wdata0;
`ifdef RAM_ARB_BOUNDS_CHECK_EN
          bad = a[9];
`else
          bad = 1'b0;
`endif
          e_gnt[cyc][s] = 1'b1;
          if (bad) begin
            e_err[cyc][s] = 1'b1;
            free_at = cyc + 1;
          end else begin
            m_addr = a;
            m_data = d;
            e_busy[cyc] = 1'b1;
            if (w) begin
              e_we[cyc] = 1'b1;
              ref_mem[a] = d;
              free_at = cyc + 2;
            end else begin
              e_busy[cyc+1] = 1'b1;
              e_rv[cyc+3][s] = 1'b1;
              if (s) e_rdv1[cyc+3] = ref_mem[a];
              else   e_rdv0[cyc+3] = ref_mem[a];
              free_at = cyc + 3;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("gnt",      {bus.gnt1, bus.gnt0},       e_gnt[cyc]);
        chk("err",      {bus.err1, bus.err0},       e_err[cyc]);
        chk("rvalid",   {bus.rvalid1, bus.rvalid0}, e_rv[cyc]);
        chk("ram_we",   bus.ram_we,                 e_we[cyc]);
        chk("busy",     bus.busy,                   e_busy[cyc]);
        chk("ram_addr", bus.ram_addr,               m_addr);
        chk("ram_data", bus.ram_data,               m_data);
        chk("rdata0",   bus.rdata0,                 m_rdata0);
        chk("rdata1",   bus.rdata1,                 m_rdata1);
      end
    end
  end

  task automatic set_cmd(input int i, input logic r, input logic w, input logic [9:0] a,
                         input logic [15:0] d);
    if (i == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Raise a request and wait (bounded) for its grant; called at a negedge.
  task automatic issue(input int i, input logic w, input logic [9:0] a, input logic [15:0] d,
                       input bit drop, output int gcyc);
    set_cmd(i, 1'b1, w, a, d);
    gcyc = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if ((i == 0 && bus.gnt0) || (i == 1 && bus.gnt1)) begin
        gcyc = cyc;
        break;
      end
    end
    if (gcyc < 0) begin
      nvec++; nerr++;
      $display("FAIL gnt_timeout requester %0d", i);
    end
    if (drop) set_cmd(i, 1'b0, w, a, d);
  endtask

  task automatic wait_rv(input int i, output int rcyc);
    rcyc = -1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if ((i == 0 && bus.rvalid0) || (i == 1 && bus.rvalid1)) begin
        rcyc = cyc;
        break;
      end
    end
    if (rcyc < 0) begin
      nvec++; nerr++;
      $display("FAIL rvalid_timeout requester %0d", i);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  int g0, g1, r0, r1, gw;
  int order[$];

  task automatic stream(input int i);
    int g;
    for (int n = 0; n < 4; n++) begin
      issue(i, ((n + i) % 2) == 0, 10'h030 + 10'(i * 16 + n), 16'h5A00 + 16'(i * 16 + n),
            n == 3, g);
      order.push_back(i);
    end
  endtask

  initial begin
    set_cmd(0, 1'b0, 1'b0, '0, '0);
    set_cmd(1, 1'b0, 1'b0, '0, '0);

    // 1: reset held with both requesting, then requester 0 wins the first tie.
    set_cmd(0, 1'b1, 1'b0, 10'h001, '0);
    set_cmd(1, 1'b1, 1'b0, 10'h002, '0);
    repeat (3) @(negedge clk);
    chk("t1_rst_busy", bus.busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    g0 = cyc;
    bus.req0 = 1'b0;
    issue(1, 1'b0, 10'h002, '0, 1'b1, g1);
    chk("t1_gnt1_gap", g1 - g0, 3);
    repeat (4) @(negedge clk);

    // 2: write then read back through requester 0.
    issue(0, 1'b1, 10'h005, 16'hBEEF, 1'b1, gw);
    chk("t2_we", bus.ram_we, 1'b1);
    issue(0, 1'b0, 10'h005, '0, 1'b1, g0);
    wait_rv(0, r0);
    chk("t2_lat", r0 - g0, 3);
    chk("t2_rdata", bus.rdata0, 16'hBEEF);
    repeat (2) @(negedge clk);

    // 3: simultaneous reads after reset.
    issue(0, 1'b1, 10'h010, 16'h1111, 1'b1, gw);
    issue(1, 1'b1, 10'h020, 16'h2222, 1'b1, gw);
    @(negedge clk);
    do_reset(2);
    fork
      issue(0, 1'b0, 10'h010, '0, 1'b1, g0);
      issue(1, 1'b0, 10'h020, '0, 1'b1, g1);
    join
    wait_rv(1, r1);
    chk("t3_order", g1 - g0, 3);
    chk("t3_rdata0", bus.rdata0, 16'h1111);
    chk("t3_rdata1", bus.rdata1, 16'h2222);
    repeat (2) @(negedge clk);

    // 4: both continuously requesting, grants alternate.
    do_reset(1);
    order.delete();
    fork
      stream(0);
      stream(1);
    join
    chk("t4_count", order.size(), 8);
    for (int j = 0; j < order.size(); j++) chk("t4_alt", order[j], j % 2);
    repeat (6) @(negedge clk);

    // 5: reset during RDWAIT kills the read.
    issue(0, 1'b0, 10'h005, '0, 1'b1, g0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_rdata0", bus.rdata0, 16'h0000);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_rvalid", bus.rvalid0, 1'b0);
    end

    // 6: upper-bank address handling.
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    issue(1, 1'b1, 10'h200, 16'hDEAD, 1'b1, gw);
    chk("t6_err1", bus.err1, 1'b1);
    chk("t6_we", bus.ram_we, 1'b0);
    issue(1, 1'b1, 10'h1FF, 16'h1234, 1'b1, gw);
    issue(1, 1'b0, 10'h1FF, '0, 1'b1, g1);
    wait_rv(1, r1);
    chk("t6_rdata1", bus.rdata1, 16'h1234);
`else
    issue(1, 1'b1, 10'h200, 16'hCAFE, 1'b1, gw);
    chk("t6_err1", bus.err1, 1'b0);
    chk("t6_addr", bus.ram_addr, 10'h200);
    issue(1, 1'b0, 10'h200, '0, 1'b1, g1);
    wait_rv(1, r1);
    chk("t6_rdata1", bus.rdata1, 16'hCAFE);
`endif
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
